rt_out_buffer: RTL
==================

RT_OUT_BUFFER -- requirements
Module: rt_out_buffer

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 8, entry count; power of two, minimum 2.
REQ-003 Parameter CNT_W, default 16, width of drop counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 clr  input  1  synchronous flush; empties buffer, clears flags and counter.
REQ-007 rt_in_data  input  WIDTH  word from the router interpreter output.
REQ-008 rt_in_valid  input  1  one-cycle strobe, word present; the source cannot stall.
REQ-009 out_data  output  WIDTH  head-of-queue word, valid when out_valid=1.
REQ-010 out_valid  output  1  queue non-empty.
REQ-011 out_ready  input  1  consumer accepts the head word when out_valid=1.
REQ-012 full_n  output  1  low when occupancy equals DEPTH.
REQ-013 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 overflow  output  1  sticky; set when an incoming word is dropped.
REQ-015 drop_cnt  output  CNT_W  saturating count of dropped words.

Function
REQ-016 Circular buffer with rd_ptr/wr_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH, plus separate occupancy counter.
REQ-017 First-word-fall-through: out_data shows mem[rd_ptr] combinationally; a word written at edge N is visible with out_valid=1 after edge N (1-cycle latency).
REQ-018 Pop = out_valid & out_ready; pop advances rd_ptr and decrements count at the same edge.
REQ-019 Push = rt_in_valid & (count<DEPTH | pop); push writes mem[wr_ptr] and advances wr_ptr.
REQ-020 Simultaneous push and pop: count unchanged; push when full is accepted if a pop occurs in the same cycle.
REQ-021 Simultaneous push and pop when empty: pop ignored (out_valid=0); push accepted, count becomes 1.
REQ-022 Drop = rt_in_valid & count==DEPTH & ~pop; word discarded, overflow set, drop_cnt increments.
REQ-023 drop_cnt saturates at 2^CNT_W-1 and does not wrap.
REQ-024 out_ready while out_valid=0 has no effect.
REQ-025 full_n = (count != DEPTH); out_valid = (count != 0); both are derived from registered count.
REQ-026 clr has priority over push/pop in the same cycle: pointers, count, overflow and drop_cnt go to 0; the incoming word is discarded.
REQ-027 Memory contents are not reset; only pointers, count and flags are.

Reset
REQ-028 reset assertion immediately forces rd_ptr=0, wr_ptr=0, count=0, overflow=0, drop_cnt=0; hence out_valid=0 and full_n=1.
REQ-029 reset mid-operation discards all queued words; no push or pop occurs on an edge where reset is high.
REQ-030 The first push is accepted on the first rising edge after reset deassertion.

Structure
REQ-031 Package rt_pkg holds RT_WIDTH=8, RT_DEPTH=8, RT_CNT_W=16 defaults and the derived RT_PTR_W/RT_COUNT_W localparams.
REQ-032 One sub-module, rt_sat_counter (CNT_W, inc, clr, async reset), implements drop_cnt.
REQ-033 Storage is a plain register array, DEPTH x WIDTH, with no vendor RAM primitive.

Verification
REQ-034 Reset, then push 0x11,0x22,0x33 with out_ready=0 -> count=3, out_data=0x11; then out_ready=1 for 3 cycles -> outputs 0x11,0x22,0x33 in order and count=0.
REQ-035 With out_ready=0, push 8 words (0x00..0x07) -> full_n=0; push 0xAA -> dropped, overflow=1, drop_cnt=1, out_data stays 0x00.
REQ-036 Full buffer, push 0xBB together with a pop -> out_data advances to 0x01, count stays 8, overflow unchanged, and 0xBB is later read last.
REQ-037 Push continuously with out_ready=1 for 20 cycles (pointer wrap) -> each word appears at out_data 1 cycle after its push, and count never exceeds 1.
REQ-038 With 5 words queued, assert reset asynchronously mid-cycle -> out_valid=0, count=0 before the next edge; after release, push 0x5A -> out_data=0x5A.
REQ-039 With CNT_W=2, cause 5 drops -> drop_cnt=3 (saturated); then clr -> drop_cnt=0, overflow=0, count=0.

Source files
------------

// File: rtl/rt_pkg.sv
// Shared defaults, derived widths and per-cycle operation decode for the router output buffer.
package rt_pkg;

  localparam int unsigned RT_WIDTH   = 8;
  localparam int unsigned RT_DEPTH   = 8;
  localparam int unsigned RT_CNT_W   = 16;
  localparam int unsigned RT_PTR_W   = $clog2(RT_DEPTH);
  localparam int unsigned RT_COUNT_W = RT_PTR_W + 1;

  // What the buffer does with the current cycle's inputs.
  typedef struct packed {
    logic push;
    logic pop;
    logic drop;
  } rt_op_t;

  // A pop frees a slot in the same cycle, so a full buffer still takes a word
  // when the consumer reads. A flush overrides everything.
  function automatic rt_op_t rt_decode(logic in_valid, logic out_ready, logic empty,
                                       logic full, logic clr);
    rt_op_t op;
    op.pop  = ~clr & ~empty & out_ready;
    op.push = ~clr & in_valid & (~full | op.pop);
    op.drop = ~clr & in_valid & full & ~op.pop;
    return op;
  endfunction

endpackage

// File: rtl/rt_out_buffer_if.sv
// Producer/consumer stream bundle for the router output buffer.
interface rt_out_buffer_if
  import rt_pkg::*;
#(
  parameter int unsigned WIDTH = RT_WIDTH
);

  logic [WIDTH-1:0] rt_in_data;
  logic             rt_in_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             full_n;

  // Buffer side.
  modport slave (
    input  rt_in_data,
    input  rt_in_valid,
    input  out_ready,
    output out_data,
    output out_valid,
    output full_n
  );

  // Environment side: interpreter producing words and consumer draining them.
  modport master (
    output rt_in_data,
    output rt_in_valid,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  full_n
  );

endinterface

// File: rtl/rt_sat_counter.sv
// Saturating event counter with synchronous clear and asynchronous reset.
module rt_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise increment until all ones and hold there.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/rt_out_buffer.sv
// First-word-fall-through output buffer behind the router interpreter. The source
// cannot stall, so words arriving while full (and not draining) are dropped and counted.
module rt_out_buffer
  import rt_pkg::*;
#(
  parameter int unsigned WIDTH = RT_WIDTH,
  parameter int unsigned DEPTH = RT_DEPTH,
  parameter int unsigned CNT_W = RT_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  rt_out_buffer_if.slave         bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned COUNT_W = PTR_W + 1;
  localparam logic [COUNT_W-1:0] FullCount = COUNT_W'(DEPTH);

  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];

  logic   empty;
  logic   full;
  rt_op_t op;

  assign empty = (count_q == '0);
  assign full  = (count_q == FullCount);
  assign op    = rt_decode(bus.rt_in_valid, bus.out_ready, empty, full, clr);

  // Pointer, occupancy and sticky-flag next state; pointers wrap naturally at DEPTH.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | op.drop;
    if (clr) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (op.pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (op.push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      unique case ({op.push, op.pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage write; contents are left alone by reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (op.push) begin
      mem_q[wr_ptr_q] <= bus.rt_in_data;
    end
  end

  rt_sat_counter #(
    .CNT_W (CNT_W)
  ) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (op.drop),
    .cnt   (drop_cnt)
  );

  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.out_valid = ~empty;
  assign bus.full_n    = ~full;
  assign count         = count_q;
  assign overflow      = overflow_q;

endmodule
